voice_phase_scheduler: RTL and testbench

Time-multiplexed voice scheduler that feeds the pipelined quarter-wave sine generator. It holds NVOICES voice slots, each with a MIDI note, a 16-bit phase accumulator and a phase increment. It allocates and frees slots on note-on/note-off commands. Every enabled cycle it issues one slot, in round-robin order, to the sine pipeline's i_phase/i_midi/i_valid inputs, so one sine pipeline serves all voices.

---
 rtl/voice_phase_scheduler.sv | 131 +++++++++++++
 tb/tb_voice_phase_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_phase_scheduler.sv
// rtl/voice_phase_scheduler.sv - round-robin voice slot scheduler feeding a shared sine pipeline
module voice_phase_scheduler #(
  parameter  int NVOICES = 10,
  localparam int SW = (NVOICES > 1) ? $clog2(NVOICES) : 1,
  localparam int CW = $clog2(NVOICES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          i_note_on,
  input  logic          i_note_off,
  input  logic [6:0]    i_midi,
  input  logic [15:0]   i_inc,
  output logic          o_cmd_ready,
  output logic          o_drop,
  output logic [15:0]   o_phase,
  output logic [6:0]    o_midi,
  output logic          o_valid,
  output logic [SW-1:0] o_slot,
  output logic          o_frame_start,
  output logic [CW-1:0] o_active_count
);

  logic [NVOICES-1:0] r_active;
  logic [6:0]         r_midi  [NVOICES];
  logic [15:0]        r_phase [NVOICES];
  logic [15:0]        r_inc   [NVOICES];
  logic [SW-1:0]      r_ptr;

  logic [15:0]        r_o_phase;
  logic [6:0]         r_o_midi;
  logic               r_o_valid;
  logic [SW-1:0]      r_o_slot;
  logic               r_o_fs;
  logic               r_o_drop;
  logic [CW-1:0]      r_count;

  logic [NVOICES-1:0] w_match;
  logic [NVOICES-1:0] w_off_hit;
  logic [SW-1:0]      w_free_idx;
  logic               w_have_free;
  logic               w_on_cmd;
  logic               w_retrig;
  logic               w_alloc;
  logic               w_reject;
  logic               w_off_any;

  assign o_cmd_ready    = clk_en;
  assign o_drop         = r_o_drop;
  assign o_phase        = r_o_phase;
  assign o_midi         = r_o_midi;
  assign o_valid        = r_o_valid;
  assign o_slot         = r_o_slot;
  assign o_frame_start  = r_o_fs;
  assign o_active_count = r_count;

  // All command decisions look only at pre-cycle slot state; a simultaneous
  // note-off always shares i_midi with the note-on, so the note-on is dropped.
  always_comb begin
    w_match     = '0;
    w_off_hit   = '0;
    w_free_idx  = '0;
    w_have_free = 1'b0;
    for (int i = 0; i < NVOICES; i++) begin
      w_match[i]   = r_active[i] && (r_midi[i] == i_midi);
      w_off_hit[i] = i_note_off && w_match[i];
    end
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_idx  = SW'(i);
        w_have_free = 1'b1;
      end
    end
    w_off_any = |w_off_hit;
    w_on_cmd  = i_note_on && !i_note_off;
    w_retrig  = w_on_cmd && (|w_match);
    w_alloc   = w_on_cmd && !(|w_match) && w_have_free;
    w_reject  = w_on_cmd && !(|w_match) && !w_have_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        r_midi[i]  <= '0;
        r_phase[i] <= '0;
        r_inc[i]   <= '0;
      end
      r_ptr     <= '0;
      r_o_phase <= '0;
      r_o_midi  <= '0;
      r_o_valid <= 1'b0;
      r_o_slot  <= '0;
      r_o_fs    <= 1'b0;
      r_o_drop  <= 1'b0;
      r_count   <= '0;
    end else if (clk_en) begin
      r_o_phase <= r_phase[r_ptr];
      r_o_midi  <= r_midi[r_ptr];
      r_o_valid <= r_active[r_ptr];
      r_o_slot  <= r_ptr;
      r_o_fs    <= (r_ptr == '0);
      r_o_drop  <= w_reject;
      r_count   <= r_count + CW'(w_alloc) - CW'(w_off_any);
      r_ptr     <= (r_ptr == SW'(NVOICES - 1)) ? '0 : r_ptr + 1'b1;

      // Later assignments win: a command write to the issued slot overrides its accumulate.
      for (int i = 0; i < NVOICES; i++) begin
        if (r_active[i] && (r_ptr == SW'(i))) begin
          r_phase[i] <= r_phase[i] + r_inc[i];
        end
        if (w_off_hit[i]) begin
          r_active[i] <= 1'b0;
        end
        if (w_retrig && w_match[i]) begin
          r_phase[i] <= '0;
          r_inc[i]   <= i_inc;
        end
        if (w_alloc && (w_free_idx == SW'(i))) begin
          r_active[i] <= 1'b1;
          r_midi[i]   <= i_midi;
          r_phase[i]  <= '0;
          r_inc[i]    <= i_inc;
        end
      end
    end else begin
      r_o_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// tb/tb_voice_phase_scheduler.sv - scoreboard bench for voice_phase_scheduler
module tb_voice_phase_scheduler;
  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        i_note_on = 1'b0;
  logic        i_note_off = 1'b0;
  logic [6:0]  i_midi = '0;
  logic [15:0] i_inc = '0;
  logic        o_cmd_ready;
  logic        o_drop;
  logic [15:0] o_phase;
  logic [6:0]  o_midi;
  logic        o_valid;
  logic [3:0]  o_slot;
  logic        o_frame_start;
  logic [3:0]  o_active_count;

  voice_phase_scheduler #(.NVOICES(N)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_note_on(i_note_on), .i_note_off(i_note_off), .i_midi(i_midi), .i_inc(i_inc),
    .o_cmd_ready(o_cmd_ready), .o_drop(o_drop), .o_phase(o_phase), .o_midi(o_midi),
    .o_valid(o_valid), .o_slot(o_slot), .o_frame_start(o_frame_start),
    .o_active_count(o_active_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  slot;
    logic        valid;
    logic [15:0] phase;
    logic [6:0]  midi;
    logic        fs;
    logic        drop;
    logic [3:0]  count;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs[$];
  int   n_pass = 0;
  int   n_total = 0;

  bit          m_act [N];
  logic [6:0]  m_midi[N];
  logic [15:0] m_ph  [N];
  logic [15:0] m_inc [N];
  int          m_ptr;
  int          m_cnt;
  rec_t        m_out;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step(bit rs, bit en, bit on, bit off, logic [6:0] midi, logic [15:0] inc);
    int match_i;
    int free_i;
    @(negedge clk);
    rst = rs; clk_en = en; i_note_on = on; i_note_off = off; i_midi = midi; i_inc = inc;
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_midi[i] = 0; m_ph[i] = 0; m_inc[i] = 0;
      end
      m_ptr = 0; m_cnt = 0;
      m_out.slot = 0; m_out.valid = 0; m_out.phase = 0; m_out.midi = 0;
      m_out.fs = 0; m_out.drop = 0; m_out.count = 0;
    end else if (en) begin
      match_i = -1; free_i = -1;
      for (int i = 0; i < N; i++) begin
        if (m_act[i] && m_midi[i] == midi && match_i < 0) match_i = i;
        if (!m_act[i] && free_i < 0) free_i = i;
      end
      m_out.slot  = 4'(m_ptr);
      m_out.valid = m_act[m_ptr];
      m_out.phase = m_ph[m_ptr];
      m_out.midi  = m_midi[m_ptr];
      m_out.fs    = (m_ptr == 0);
      m_out.drop  = 0;
      if (m_act[m_ptr]) m_ph[m_ptr] = m_ph[m_ptr] + m_inc[m_ptr];
      if (off && match_i >= 0) begin
        m_act[match_i] = 0;
        m_cnt--;
      end
      if (on && !off) begin
        if (match_i >= 0) begin
          m_ph[match_i] = 0; m_inc[match_i] = inc;
        end else if (free_i >= 0) begin
          m_act[free_i] = 1; m_midi[free_i] = midi; m_ph[free_i] = 0; m_inc[free_i] = inc;
          m_cnt++;
        end else begin
          m_out.drop = 1;
        end
      end
      m_ptr = (m_ptr + 1) % N;
      m_out.count = 4'(m_cnt);
    end else begin
      m_out.drop = 0;
    end
    exp_q.push_back(m_out);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 7'd0, 16'd0);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 7'd0, 16'd0);
    step(1, 1, 0, 0, 7'd0, 16'd0);
  endtask

  initial begin : monitor
    rec_t e;
    rec_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.slot = o_slot; a.valid = o_valid; a.phase = o_phase; a.midi = o_midi;
        a.fs = o_frame_start; a.drop = o_drop; a.count = o_active_count;
        obs.push_back(a);
        chk("sb_slot",  a.slot,  e.slot);
        chk("sb_valid", a.valid, e.valid);
        chk("sb_phase", a.phase, e.phase);
        chk("sb_midi",  a.midi,  e.midi);
        chk("sb_fs",    a.fs,    e.fs);
        chk("sb_drop",  a.drop,  e.drop);
        chk("sb_count", a.count, e.count);
        chk("sb_cmd_ready", o_cmd_ready, clk_en);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int idx;
    logic [15:0] exp_ph [4];

    // reset state and idle rotation
    do_reset();
    chk("rst_slot",  obs[obs.size()-1].slot,  0);
    chk("rst_valid", obs[obs.size()-1].valid, 0);
    chk("rst_phase", obs[obs.size()-1].phase, 0);
    chk("rst_midi",  obs[obs.size()-1].midi,  0);
    chk("rst_fs",    obs[obs.size()-1].fs,    0);
    chk("rst_drop",  obs[obs.size()-1].drop,  0);
    chk("rst_count", obs[obs.size()-1].count, 0);
    obs.delete();
    idle(20);
    for (int k = 0; k < 20; k++) begin
      chk("t1_slot",  obs[k].slot,  k % 10);
      chk("t1_valid", obs[k].valid, 0);
      chk("t1_fs",    obs[k].fs,    (k % 10) == 0);
      chk("t1_count", obs[k].count, 0);
    end

    // note-on at ptr=3 lands in slot 0
    idle(3);
    obs.delete();
    step(0, 1, 1, 0, 7'd60, 16'h0100);
    idle(30);
    exp_ph[0] = 16'h0000; exp_ph[1] = 16'h0100; exp_ph[2] = 16'h0200;
    n = 0;
    foreach (obs[k]) begin
      if (obs[k].valid) begin
        chk("t2_slot", obs[k].slot, 0);
        chk("t2_midi", obs[k].midi, 60);
        if (n < 3) chk("t2_phase", obs[k].phase, exp_ph[n]);
        n++;
      end
    end
    chk("t2_nissue", n, 3);
    chk("t2_count", obs[obs.size()-1].count, 1);

    // modulo wrap of the accumulator
    obs.delete();
    step(0, 1, 1, 0, 7'd61, 16'hF000);
    idle(40);
    exp_ph[0] = 16'h0000; exp_ph[1] = 16'hF000; exp_ph[2] = 16'hE000; exp_ph[3] = 16'hD000;
    n = 0;
    foreach (obs[k]) begin
      if (obs[k].valid && obs[k].slot == 4'd1) begin
        if (n < 4) chk("t3_phase", obs[k].phase, exp_ph[n]);
        n++;
      end
    end
    chk("t3_enough", n >= 4, 1);

    // fill, reject, free, reallocate
    do_reset();
    obs.delete();
    for (int m = 40; m <= 50; m++) step(0, 1, 1, 0, 7'(m), 16'h0010);
    chk("t4_nodrop9", obs[9].drop, 0);
    chk("t4_drop",    obs[10].drop, 1);
    chk("t4_full",    obs[10].count, 10);
    step(0, 1, 0, 1, 7'd45, 16'h0000);
    chk("t4_off_count", obs[11].count, 9);
    step(0, 1, 1, 0, 7'd70, 16'h0010);
    chk("t4_realloc_count", obs[12].count, 10);
    chk("t4_realloc_drop",  obs[12].drop, 0);
    idle(10);
    idx = -1;
    for (int k = 13; k < obs.size(); k++) if (obs[k].slot == 4'd5 && idx < 0) idx = k;
    chk("t4_slot5_seen", idx >= 0, 1);
    if (idx >= 0) begin
      chk("t4_slot5_valid", obs[idx].valid, 1);
      chk("t4_slot5_midi",  obs[idx].midi, 70);
      chk("t4_slot5_phase", obs[idx].phase, 0);
    end

    // retrigger, then simultaneous on/off
    do_reset();
    step(0, 1, 1, 0, 7'd60, 16'h0100);
    idle(15);
    obs.delete();
    step(0, 1, 1, 0, 7'd60, 16'h0200);
    chk("t5_retrig_count", obs[0].count, 1);
    idle(30);
    exp_ph[0] = 16'h0000; exp_ph[1] = 16'h0200; exp_ph[2] = 16'h0400;
    n = 0;
    for (int k = 1; k < obs.size(); k++) begin
      if (obs[k].valid) begin
        chk("t5_slot", obs[k].slot, 0);
        if (n < 3) chk("t5_phase", obs[k].phase, exp_ph[n]);
        n++;
      end
    end
    chk("t5_nissue", n, 3);
    chk("t5_count", obs[obs.size()-1].count, 1);
    obs.delete();
    step(0, 1, 1, 1, 7'd60, 16'h0300);
    chk("t5_onoff_count", obs[0].count, 0);
    chk("t5_onoff_drop",  obs[0].drop, 0);
    idle(10);
    n = 0;
    foreach (obs[k]) if (obs[k].valid) n++;
    chk("t5_no_valid", n, 0);

    // clk_en gating and mid-run reset
    do_reset();
    obs.delete();
    step(0, 1, 1, 0, 7'd60, 16'h0100);
    step(0, 1, 0, 0, 7'd0, 16'h0000);
    step(0, 0, 1, 0, 7'd61, 16'h0100);
    step(0, 0, 0, 1, 7'd60, 16'h0000);
    step(0, 1, 0, 0, 7'd0, 16'h0000);
    chk("t6_slot0", obs[0].slot, 0);
    chk("t6_slot1", obs[1].slot, 1);
    chk("t6_hold1", obs[2].slot, 1);
    chk("t6_hold2", obs[3].slot, 1);
    chk("t6_dis_drop", obs[3].drop, 0);
    chk("t6_slot2", obs[4].slot, 2);
    chk("t6_count", obs[4].count, 1);
    obs.delete();
    idle(50);
    n = 0;
    foreach (obs[k]) if (obs[k].valid) begin
      chk("t6_phase", obs[k].phase, n * 16'h0100);
      n++;
    end
    chk("t6_nissue", n, 5);
    step(1, 1, 0, 0, 7'd0, 16'h0000);
    chk("t6_rst_phase", obs[obs.size()-1].phase, 0);
    chk("t6_rst_valid", obs[obs.size()-1].valid, 0);
    chk("t6_rst_count", obs[obs.size()-1].count, 0);
    chk("t6_rst_fs",    obs[obs.size()-1].fs, 0);
    idle(1);
    chk("t6_after_slot", obs[obs.size()-1].slot, 0);
    chk("t6_after_fs",   obs[obs.size()-1].fs, 1);
    chk("t6_after_valid", obs[obs.size()-1].valid, 0);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
